sum_seg_sequencer: RTL
======================

Name: sum_seg_sequencer

Overview:
Downstream consumer of the registered 4-bit adder result: {cout, sum[3:0]}, range 0..31.
- Converts the latched sum to two decimal digits.
- Plays them one after the other on a single seven-segment display (uo_out), with blank gaps so that repeated digits stay distinguishable.
- Runs continuously until a new sum is loaded or reset is asserted.

Parameters:
DIGIT_TICKS, 24'd10_000_000, clock cycles each digit is shown (must be >= 1)
GAP_TICKS, 24'd2_500_000, clock cycles of blank display after each digit (must be >= 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sum_in  input  5  adder result {cout, sum[3:0]}, unsigned 0..31
sum_valid  input  1  single-cycle load strobe; sum_in sampled when high
seg_out  output  7  segments {g,f,e,d,c,b,a}, active-high, registered
dp_out  output  1  decimal point, high while the tens digit is shown, registered
digit_sel  output  1  1 = tens digit on display, 0 = ones digit or blank, registered
busy  output  1  high whenever state != IDLE, registered

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high; reset is sampled on the rising clk edge.
- Reset state: state = IDLE, tick counter = 0, latched value = 0. Outputs: seg_out = 7'h00, dp_out = 0, digit_sel = 0, busy = 0.
- Reset priority: reset beats sum_valid on the same edge. Reset mid-sequence blanks the display on the next cycle.
- Load:
  - On an edge with sum_valid = 1: latch sum_in, then split it into tens = value/10 (0..3) and ones = value%10.
  - Tick counter clears to 0.
  - Next state is TENS if tens != 0, otherwise ONES.
  - The outputs update on the same edge, so the first digit is visible 1 cycle after the strobe.
- States: IDLE, TENS, GAP1, ONES, GAP2.
  - IDLE: display blank. Leaves only on sum_valid.
  - TENS: seg_out = pattern(tens), dp_out = 1, digit_sel = 1. Lasts DIGIT_TICKS cycles, then -> GAP1.
  - GAP1: seg_out = 0, dp_out = 0, digit_sel = 0. Lasts GAP_TICKS cycles, then -> ONES.
  - ONES: seg_out = pattern(ones), dp_out = 0, digit_sel = 0. Lasts DIGIT_TICKS cycles, then -> GAP2.
  - GAP2: display blank. Lasts GAP_TICKS cycles, then -> TENS if tens != 0, else -> ONES. The sequence loops indefinitely.
- Leading-zero suppression: when tens == 0, TENS and GAP1 are never entered. The loop is ONES -> GAP2 -> ONES, giving a period of DIGIT_TICKS + GAP_TICKS.
- Tick counter:
  - Counts 0..N-1 within a state; the transition happens on the edge where count == N-1.
  - Clears to 0 on every state change.
  - Width is 24 bits and never wraps.
- New load mid-sequence: sum_valid in any state re-latches the value and restarts from the first digit state with the counter cleared. Any in-progress digit or gap is abandoned.
- Full sequence period with tens != 0: 2*DIGIT_TICKS + 2*GAP_TICKS.
- Segment patterns: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
- Values 30 and 31 display as "3","0" and "3","1".
- Inputs are assumed to be synchronous to clk; the block adds no input synchronizers.

Optional Feature:
SUM_HEX_MODE_EN
- Defined: the value is shown as two hex digits instead of decimal. The high digit is sum_in[4] (0..1) and the low digit is sum_in[3:0].
- Extra patterns: A=77 b=7C C=39 d=5E E=79 F=71.
- Leading-zero suppression applies to a high digit of 0. All state, timing and strobe rules are unchanged.
- Not defined: decimal behaviour as above, and the hex patterns are not synthesized.

Test Plan:
All scenarios use DIGIT_TICKS=4, GAP_TICKS=2.
- Reset, then hold idle 20 cycles -> seg_out=00, dp_out=0, digit_sel=0, busy=0 throughout.
- sum_in=23 with a sum_valid pulse -> starting 1 cycle later: seg_out=5B dp=1 for 4 cycles; 00 for 2; 4F dp=0 for 4; 00 for 2; then 5B again (period 12); busy=1.
- sum_in=7 with a sum_valid pulse -> seg_out=07 for 4 cycles, 00 for 2, repeat. dp_out and digit_sel stay 0; TENS is never entered.
- sum_in=31, then sum_in=10 strobed on the 2nd cycle of ONES -> next cycle seg_out=06 dp=1 digit_sel=1, counter restarted (4 full cycles); afterwards ones shows 3F.
- sum_in=0 strobed, then reset and sum_valid (sum_in=19) asserted together mid-sequence -> reset wins: next cycle seg_out=00, busy=0, and the display stays blank.
- SUM_HEX_MODE_EN defined, sum_in=31 -> 06 dp=1 for 4 cycles, 00 for 2, 71 for 4, 00 for 2; sum_in=12 -> only C (39) shown, period 6.

Source files
------------

// File: rtl/sum_seg_sequencer.sv
// rtl/sum_seg_sequencer.sv - plays a latched 0..31 sum as two digits on one seven-segment display; `SUM_HEX_MODE_EN selects hex digits
module sum_seg_sequencer #(
    parameter logic [23:0] DIGIT_TICKS = 24'd10_000_000,
    parameter logic [23:0] GAP_TICKS   = 24'd2_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] sum_in,
    input  logic       sum_valid,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic       digit_sel,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, TENS, GAP1, ONES, GAP2} state_t;

    state_t      state;
    logic [23:0] tick_cnt;
    logic [4:0]  value_q;

    function automatic logic [3:0] hi_digit(input logic [4:0] v);
`ifdef SUM_HEX_MODE_EN
        return {3'b000, v[4]};
`else
        if (v >= 5'd30)      return 4'd3;
        else if (v >= 5'd20) return 4'd2;
        else if (v >= 5'd10) return 4'd1;
        else                 return 4'd0;
`endif
    endfunction

    function automatic logic [3:0] lo_digit(input logic [4:0] v);
`ifdef SUM_HEX_MODE_EN
        return v[3:0];
`else
        logic [4:0] r;
        r = v - ({1'b0, hi_digit(v)} * 5'd10);
        return r[3:0];
`endif
    endfunction

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
`ifdef SUM_HEX_MODE_EN
            4'hA:    return 7'h77;
            4'hB:    return 7'h7C;
            4'hC:    return 7'h39;
            4'hD:    return 7'h5E;
            4'hE:    return 7'h79;
            4'hF:    return 7'h71;
`endif
            default: return 7'h00;
        endcase
    endfunction

    // Output word {busy, digit_sel, dp, seg} for the state being entered.
    function automatic logic [9:0] display(input state_t s, input logic [4:0] v);
        case (s)
            TENS:    return {1'b1, 1'b1, 1'b1, seg_pattern(hi_digit(v))};
            ONES:    return {1'b1, 1'b0, 1'b0, seg_pattern(lo_digit(v))};
            GAP1,
            GAP2:    return {1'b1, 1'b0, 1'b0, 7'h00};
            default: return 10'h000;
        endcase
    endfunction

    function automatic state_t first_state(input logic [4:0] v);
        return (hi_digit(v) != 4'd0) ? TENS : ONES;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state                               <= IDLE;
            tick_cnt                            <= 24'd0;
            value_q                             <= 5'd0;
            {busy, digit_sel, dp_out, seg_out}  <= 10'h000;
        end else if (sum_valid) begin
            state                               <= first_state(sum_in);
            tick_cnt                            <= 24'd0;
            value_q                             <= sum_in;
            {busy, digit_sel, dp_out, seg_out}  <= display(first_state(sum_in), sum_in);
        end else begin
            case (state)
                TENS: begin
                    if (tick_cnt == DIGIT_TICKS - 24'd1) begin
                        state                              <= GAP1;
                        tick_cnt                           <= 24'd0;
                        {busy, digit_sel, dp_out, seg_out} <= display(GAP1, value_q);
                    end else begin
                        tick_cnt <= tick_cnt + 24'd1;
                    end
                end
                GAP1: begin
                    if (tick_cnt == GAP_TICKS - 24'd1) begin
                        state                              <= ONES;
                        tick_cnt                           <= 24'd0;
                        {busy, digit_sel, dp_out, seg_out} <= display(ONES, value_q);
                    end else begin
                        tick_cnt <= tick_cnt + 24'd1;
                    end
                end
                ONES: begin
                    if (tick_cnt == DIGIT_TICKS - 24'd1) begin
                        state                              <= GAP2;
                        tick_cnt                           <= 24'd0;
                        {busy, digit_sel, dp_out, seg_out} <= display(GAP2, value_q);
                    end else begin
                        tick_cnt <= tick_cnt + 24'd1;
                    end
                end
                GAP2: begin
                    // Leading-zero suppression: loop straight back to ONES when the high digit is 0.
                    if (tick_cnt == GAP_TICKS - 24'd1) begin
                        state                              <= first_state(value_q);
                        tick_cnt                           <= 24'd0;
                        {busy, digit_sel, dp_out, seg_out} <= display(first_state(value_q), value_q);
                    end else begin
                        tick_cnt <= tick_cnt + 24'd1;
                    end
                end
                default: begin
                    state                              <= IDLE;
                    tick_cnt                           <= 24'd0;
                    {busy, digit_sel, dp_out, seg_out} <= 10'h000;
                end
            endcase
        end
    end

endmodule
